// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU issue scheduler: op codes, default width, tag type.
// Pure definitions, no logic and no latency.
// The tag id is sized for the largest supported requester count (8).
package fpu_pkg;

  localparam logic [1:0] FPU_ADD = 2'b00;
  localparam logic [1:0] FPU_SUB = 2'b01;
  localparam logic [1:0] FPU_MUL = 2'b10;
  localparam logic [1:0] FPU_DIV = 2'b11;

  localparam int FPU_BIT_SIZE = 31;
  localparam int FPU_ID_W     = 3;

  // One tag pipeline stage: is an operation in this slot, and whose is it
  typedef struct packed {
    logic                valid;
    logic [FPU_ID_W-1:0] id;
  } fpu_tag_t;

endpackage

// File: rtl/fpu_issue_scheduler_if.sv
// Bundles requester handshakes, response buffers and the FPU-side wires.
// No logic, no latency.
// slave = the scheduler's view, master = clients plus FPU.
interface fpu_issue_scheduler_if
  import fpu_pkg::*;
#(
  parameter int BIT_SIZE = FPU_BIT_SIZE,
  parameter int NREQ     = 2
);
  logic [NREQ-1:0]                req_valid;
  logic [NREQ-1:0]                req_ready;
  logic [2*NREQ-1:0]              req_op;
  logic [(BIT_SIZE+1)*NREQ-1:0]   req_opa;
  logic [(BIT_SIZE+1)*NREQ-1:0]   req_opb;
  logic [NREQ-1:0]                resp_valid;
  logic [NREQ-1:0]                resp_ready;
  logic [(BIT_SIZE+1)*NREQ-1:0]   resp_data;
  logic [NREQ-1:0]                resp_error;
  logic                           fpu_start;
  logic [1:0]                     fpu_operation;
  logic [BIT_SIZE:0]              fpu_opa;
  logic [BIT_SIZE:0]              fpu_opb;
  logic [BIT_SIZE:0]              fpu_out;
  logic                           fpu_errors;

  modport slave (
    input  req_valid, req_op, req_opa, req_opb, resp_ready, fpu_out, fpu_errors,
    output req_ready, resp_valid, resp_data, resp_error,
           fpu_start, fpu_operation, fpu_opa, fpu_opb
  );

  modport master (
    output req_valid, req_op, req_opa, req_opb, resp_ready, fpu_out, fpu_errors,
    input  req_ready, resp_valid, resp_data, resp_error,
           fpu_start, fpu_operation, fpu_opa, fpu_opb
  );
endinterface

// File: rtl/fpu_rr_arbiter.sv
// Round-robin arbiter: one-hot grant plus index, search starts after the last winner.
// Grant is combinational from the eligible vector; pointer updates one cycle later.
// Pointer moves only when the caller signals advance (an accept happened).
module fpu_rr_arbiter #(
  parameter  int NREQ = 2,
  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] i_eligible,
  input  logic            i_advance,
  output logic [NREQ-1:0] o_grant,
  output logic [IDW-1:0]  o_grant_idx
);

  logic [IDW-1:0] r_ptr;
  logic           w_found;

  // Scan requesters ptr+1 .. ptr+NREQ (wrapping) and take the first eligible one
  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    w_found     = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      if (!w_found && i_eligible[(int'(r_ptr) + i) % NREQ]) begin
        w_found                              = 1'b1;
        o_grant[(int'(r_ptr) + i) % NREQ]    = 1'b1;
        o_grant_idx                          = IDW'((int'(r_ptr) + i) % NREQ);
      end
    end
  end

  // Remember the last winner; reset value makes requester 0 first in line
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= IDW'(NREQ - 1);
    end else if (i_advance) begin
      r_ptr <= o_grant_idx;
    end
  end

endmodule

// File: rtl/fpu_issue_scheduler.sv
// Shares one fixed-latency FPU among NREQ requesters with a per-requester result buffer.
// Accept in cycle a -> fpu_start in a+1 -> resp_valid from a+2+LATENCY.
// One outstanding op per requester; a held response blocks only its own requester.
module fpu_issue_scheduler
  import fpu_pkg::*;
#(
  parameter int BIT_SIZE = FPU_BIT_SIZE,
  parameter int NREQ     = 2,
  parameter int LATENCY  = 3
) (
  input logic                  clk,
  input logic                  rst,
  fpu_issue_scheduler_if.slave sched_if
);

  localparam int DW  = BIT_SIZE + 1;
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0] r_busy;
  logic [NREQ-1:0] r_resp_vld;
  logic [NREQ-1:0] r_resp_err;
  logic [DW-1:0]   r_resp_dat [NREQ];
  logic            r_start;
  logic [1:0]      r_op;
  logic [DW-1:0]   r_opa;
  logic [DW-1:0]   r_opb;
  logic [IDW-1:0]  r_issue_id;
  fpu_tag_t        r_tag [LATENCY];

  logic [NREQ-1:0] w_elig;
  logic [NREQ-1:0] w_grant;
  logic [NREQ-1:0] w_ready;
  logic [NREQ-1:0] w_cap;
  logic [NREQ-1:0] w_cons;
  logic [IDW-1:0]  w_gidx;
  logic            w_accept;
  fpu_tag_t        w_tail;

  assign w_elig = sched_if.req_valid & ~r_busy;

  fpu_rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk         (clk),
    .rst         (rst),
    .i_eligible  (w_elig),
    .i_advance   (w_accept),
    .o_grant     (w_grant),
    .o_grant_idx (w_gidx)
  );

  // Ready is forced low while reset is asserted so nothing is accepted mid-reset
  assign w_ready  = w_grant & ~r_busy & {NREQ{~rst}};
  assign w_accept = |w_ready;
  assign w_tail   = r_tag[LATENCY-1];

  // Register the winning slice onto the FPU inputs; operands hold when idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_start    <= 1'b0;
      r_op       <= '0;
      r_opa      <= '0;
      r_opb      <= '0;
      r_issue_id <= '0;
    end else begin
      r_start <= w_accept;
      if (w_accept) begin
        r_op       <= sched_if.req_op[2*int'(w_gidx) +: 2];
        r_opa      <= sched_if.req_opa[DW*int'(w_gidx) +: DW];
        r_opb      <= sched_if.req_opb[DW*int'(w_gidx) +: DW];
        r_issue_id <= w_gidx;
      end
    end
  end

  // Tag shift register mirrors the FPU pipeline so the tail lines up with fpu_out
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < LATENCY; s++) r_tag[s] <= '0;
    end else begin
      r_tag[0] <= '{valid: r_start, id: FPU_ID_W'(r_issue_id)};
      for (int s = 1; s < LATENCY; s++) r_tag[s] <= r_tag[s-1];
    end
  end

  // Decode the tail tag into per-requester capture strobes and detect consumes
  always_comb begin
    w_cap = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_cap[k] = w_tail.valid && (w_tail.id == FPU_ID_W'(k));
    end
    w_cons = r_resp_vld & sched_if.resp_ready;
  end

  // Busy flags and response buffers; capture and consume never hit the same id
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy     <= '0;
      r_resp_vld <= '0;
      r_resp_err <= '0;
      for (int k = 0; k < NREQ; k++) r_resp_dat[k] <= '0;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        if (w_ready[k])     r_busy[k] <= 1'b1;
        else if (w_cons[k]) r_busy[k] <= 1'b0;
        if (w_cap[k]) begin
          r_resp_vld[k] <= 1'b1;
          r_resp_dat[k] <= sched_if.fpu_out;
          r_resp_err[k] <= sched_if.fpu_errors;
        end else if (w_cons[k]) begin
          r_resp_vld[k] <= 1'b0;
        end
      end
    end
  end

  // Pack the per-requester buffers onto the flat response bus
  always_comb begin
    sched_if.resp_data = '0;
    for (int k = 0; k < NREQ; k++) sched_if.resp_data[DW*k +: DW] = r_resp_dat[k];
  end

  assign sched_if.req_ready     = w_ready;
  assign sched_if.resp_valid    = r_resp_vld;
  assign sched_if.resp_error    = r_resp_err;
  assign sched_if.fpu_start     = r_start;
  assign sched_if.fpu_operation = r_op;
  assign sched_if.fpu_opa       = r_opa;
  assign sched_if.fpu_opb       = r_opb;

endmodule

// File: tb/tb_fpu_issue_scheduler.sv
// Bench for fpu_issue_scheduler: directed cases on a 2-requester/latency-3 instance,
// then randomized traffic on a 4-requester/latency-1 instance.
// A transaction-level reference model checks every cycle of whichever instance is active.
module tb_fpu_issue_scheduler;
  import fpu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  fpu_issue_scheduler_if #(.BIT_SIZE(31), .NREQ(2)) ifa ();
  fpu_issue_scheduler_if #(.BIT_SIZE(31), .NREQ(4)) ifb ();

  fpu_issue_scheduler #(.BIT_SIZE(31), .NREQ(2), .LATENCY(3)) dut_a (
    .clk(clk), .rst(rst), .sched_if(ifa)
  );
  fpu_issue_scheduler #(.BIT_SIZE(31), .NREQ(4), .LATENCY(1)) dut_b (
    .clk(clk), .rst(rst), .sched_if(ifb)
  );

  // Stand-in FPU arithmetic: any deterministic function of the operation is enough
  function automatic logic [31:0] fpu_calc(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    case (op)
      FPU_ADD: return a + b;
      FPU_SUB: return a - b;
      FPU_MUL: return a ^ {b[15:0], b[31:16]};
      default: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
    endcase
  endfunction

  function automatic logic fpu_err(input logic [1:0] op, input logic [31:0] b);
    return (op == FPU_DIV) && (b == 32'd0);
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- stimulus drivers ----------------
  int          mode;              // 0: instance A active, 1: instance B active
  logic [7:0]  d_valid;
  logic [7:0]  d_rrdy;
  logic [1:0]  d_op [8];
  logic [31:0] d_a  [8];
  logic [31:0] d_b  [8];

  always_comb begin
    ifa.req_valid  = '0;
    ifa.req_op     = '0;
    ifa.req_opa    = '0;
    ifa.req_opb    = '0;
    ifa.resp_ready = d_rrdy[1:0];
    ifb.req_valid  = '0;
    ifb.req_op     = '0;
    ifb.req_opa    = '0;
    ifb.req_opb    = '0;
    ifb.resp_ready = d_rrdy[3:0];
    if (mode == 0) begin
      ifa.req_valid = d_valid[1:0];
      for (int k = 0; k < 2; k++) begin
        ifa.req_op[2*k +: 2]   = d_op[k];
        ifa.req_opa[32*k +: 32] = d_a[k];
        ifa.req_opb[32*k +: 32] = d_b[k];
      end
    end else begin
      ifb.req_valid = d_valid[3:0];
      for (int k = 0; k < 4; k++) begin
        ifb.req_op[2*k +: 2]   = d_op[k];
        ifb.req_opa[32*k +: 32] = d_a[k];
        ifb.req_opb[32*k +: 32] = d_b[k];
      end
    end
  end

  // ---------------- FPU models (no reset, no handshake, noise when idle) ----------------
  logic [32:0] fa_pipe [3];
  logic [32:0] fb_pipe;

  always @(posedge clk) begin
    fa_pipe[0] <= ifa.fpu_start ?
                  {fpu_err(ifa.fpu_operation, ifa.fpu_opb),
                   fpu_calc(ifa.fpu_operation, ifa.fpu_opa, ifa.fpu_opb)} :
                  {1'($urandom), 32'($urandom)};
    fa_pipe[1] <= fa_pipe[0];
    fa_pipe[2] <= fa_pipe[1];
    fb_pipe    <= ifb.fpu_start ?
                  {fpu_err(ifb.fpu_operation, ifb.fpu_opb),
                   fpu_calc(ifb.fpu_operation, ifb.fpu_opa, ifb.fpu_opb)} :
                  {1'($urandom), 32'($urandom)};
  end

  assign ifa.fpu_out    = fa_pipe[2][31:0];
  assign ifa.fpu_errors = fa_pipe[2][32];
  assign ifb.fpu_out    = fb_pipe[31:0];
  assign ifb.fpu_errors = fb_pipe[32];

  // ---------------- reference model ----------------
  int          nreq, lat, cyc, m_ptr, m_acc, m_cons;
  logic        m_busy [8];
  int          m_arr  [8];
  logic [31:0] m_dat  [8];
  logic        m_err  [8];
  logic        m_start;
  logic [1:0]  m_iop;
  logic [31:0] m_ia, m_ib;

  always @(negedge clk) begin : model
    logic [7:0]  vv, rr, rv, re, exp_rr;
    logic [31:0] rd [8];
    logic        fs, rdor, exp_rv;
    logic [1:0]  fop;
    logic [31:0] fa, fb;
    int          g;
    for (int k = 0; k < 8; k++) rd[k] = '0;
    if (mode == 0) begin
      nreq = 2; lat = 3;
      rr = {6'd0, ifa.req_ready}; rv = {6'd0, ifa.resp_valid}; re = {6'd0, ifa.resp_error};
      for (int k = 0; k < 2; k++) rd[k] = ifa.resp_data[32*k +: 32];
      fs = ifa.fpu_start; fop = ifa.fpu_operation; fa = ifa.fpu_opa; fb = ifa.fpu_opb;
    end else begin
      nreq = 4; lat = 1;
      rr = {4'd0, ifb.req_ready}; rv = {4'd0, ifb.resp_valid}; re = {4'd0, ifb.resp_error};
      for (int k = 0; k < 4; k++) rd[k] = ifb.resp_data[32*k +: 32];
      fs = ifb.fpu_start; fop = ifb.fpu_operation; fa = ifb.fpu_opa; fb = ifb.fpu_opb;
    end
    vv = d_valid & ((8'd1 << nreq) - 8'd1);
    if (rst) begin
      rdor = 1'b0;
      for (int k = 0; k < 8; k++) rdor = rdor | (|rd[k]);
      chk("rst_req_ready", rr, 0);
      chk("rst_resp_valid", rv, 0);
      chk("rst_fpu_start", fs, 0);
      chk("rst_fpu_regs", (|fop) | (|fa) | (|fb), 0);
      chk("rst_resp_data_err", rdor | (|re), 0);
      for (int k = 0; k < 8; k++) m_busy[k] = 1'b0;
      m_ptr = nreq - 1; m_start = 1'b0; m_acc = 0; m_cons = 0; cyc = 0;
    end else begin
      g = -1;
      for (int i = 1; i <= nreq; i++) begin
        if (g < 0 && vv[(m_ptr + i) % nreq] && !m_busy[(m_ptr + i) % nreq]) g = (m_ptr + i) % nreq;
      end
      exp_rr = (g >= 0) ? (8'd1 << g) : 8'd0;
      chk("req_ready", rr, exp_rr);
      chk("fpu_start", fs, m_start);
      if (m_start) begin
        chk("fpu_operation", fop, m_iop);
        chk("fpu_opa", fa, m_ia);
        chk("fpu_opb", fb, m_ib);
      end
      for (int k = 0; k < nreq; k++) begin
        exp_rv = m_busy[k] && (cyc >= m_arr[k]);
        chk("resp_valid", rv[k], exp_rv);
        if (exp_rv) begin
          chk("resp_data", rd[k], m_dat[k]);
          chk("resp_error", re[k], m_err[k]);
          if (d_rrdy[k]) begin
            m_busy[k] = 1'b0;
            m_cons++;
          end
        end
      end
      m_start = (g >= 0);
      if (g >= 0) begin
        m_busy[g] = 1'b1;
        m_arr[g]  = cyc + 2 + lat;
        m_dat[g]  = fpu_calc(d_op[g], d_a[g], d_b[g]);
        m_err[g]  = fpu_err(d_op[g], d_b[g]);
        m_iop = d_op[g]; m_ia = d_a[g]; m_ib = d_b[g];
        m_ptr = g;
        m_acc++;
      end
      cyc++;
    end
  end

  // ---------------- sequencing helpers ----------------
  task automatic drive_edge();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  task automatic rand_ops(input int n);
    for (int k = 0; k < n; k++) begin
      d_op[k] = 2'($urandom);
      d_a[k]  = $urandom;
      d_b[k]  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
    end
  endtask

  int          seq [$];
  int          t, cnt0;
  logic [31:0] e1;

  initial begin
    mode = 0; rst = 1'b1; d_valid = '0; d_rrdy = 8'hFF;
    for (int k = 0; k < 8; k++) begin d_op[k] = '0; d_a[k] = '0; d_b[k] = '0; end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Single MUL from requester 0: timing and data
    drive_edge();
    d_valid = 8'h01; d_op[0] = FPU_MUL; d_a[0] = 32'h4000_0000; d_b[0] = 32'h4040_0000;
    settle();
    chk("t1_accept", ifa.req_ready, 2'b01);
    for (int n = 1; n <= 5; n++) begin
      drive_edge(); d_valid = '0;
      settle();
      if (n == 1) chk("t1_start", ifa.fpu_start, 1);
      if (n == 2) chk("t1_start_drop", ifa.fpu_start, 0);
      if (n == 4) chk("t1_not_early", ifa.resp_valid[0], 0);
      if (n == 5) begin
        chk("t1_resp_valid", ifa.resp_valid[0], 1);
        chk("t1_resp_data", ifa.resp_data[31:0], 32'h4000_4040);
      end
    end

    // Both requesters continuously valid: grants must alternate
    for (int n = 0; n < 40; n++) begin
      drive_edge(); d_valid = 8'h03; rand_ops(2);
      settle();
      if (ifa.req_ready != 2'b00) seq.push_back(ifa.req_ready[1] ? 1 : 0);
    end
    drive_edge(); d_valid = '0;
    repeat (8) drive_edge();
    chk("t2_grant_count", seq.size() >= 10, 1);
    for (int i = 1; i < seq.size(); i++) chk("t2_alternate", seq[i], 1 - seq[i-1]);

    // Requester 1 holds its result; requester 0 keeps going
    drive_edge(); d_rrdy = 8'hFD; d_valid = 8'h02; rand_ops(2);
    e1 = fpu_calc(d_op[1], d_a[1], d_b[1]);
    settle();
    t = 0;
    while (!ifa.req_ready[1] && t < 10) begin drive_edge(); settle(); t++; end
    chk("t3_accept", ifa.req_ready[1], 1);
    drive_edge(); d_valid = 8'h01;
    settle();
    t = 0;
    while (!ifa.resp_valid[1] && t < 12) begin drive_edge(); settle(); t++; end
    chk("t3_arrive", ifa.resp_valid[1], 1);
    cnt0 = 0;
    for (int n = 0; n < 10; n++) begin
      drive_edge(); d_valid = 8'h03;
      settle();
      chk("t3_hold_valid", ifa.resp_valid[1], 1);
      chk("t3_hold_data", ifa.resp_data[63:32], e1);
      chk("t3_ready1_low", ifa.req_ready[1], 0);
      if (ifa.req_ready[0]) cnt0++;
    end
    chk("t3_req0_progress", cnt0 >= 1, 1);
    drive_edge(); d_rrdy = 8'hFF; d_valid = '0;
    repeat (10) drive_edge();

    // Error flag is steered only to the requester whose op raised it
    drive_edge(); d_rrdy = 8'h00; d_valid = 8'h03; rand_ops(2);
    d_op[1] = FPU_DIV; d_b[1] = 32'd0;
    d_op[0] = FPU_ADD;
    settle();
    t = 0;
    while (ifa.resp_valid != 2'b11 && t < 20) begin drive_edge(); settle(); t++; end
    chk("t4_both_valid", ifa.resp_valid, 2'b11);
    chk("t4_error1", ifa.resp_error[1], 1);
    chk("t4_error0", ifa.resp_error[0], 0);
    chk("t4_div0_data", ifa.resp_data[63:32], 32'hFFFF_FFFF);
    drive_edge(); d_valid = '0; d_rrdy = 8'hFF;
    repeat (4) drive_edge();

    // Reset with two operations in flight
    drive_edge(); d_valid = 8'h03; rand_ops(2);
    drive_edge();
    drive_edge(); rst = 1'b1;
    settle();
    chk("t5_ready_zero", ifa.req_ready, 0);
    chk("t5_start_zero", ifa.fpu_start, 0);
    chk("t5_opa_zero", ifa.fpu_opa, 0);
    chk("t5_resp_zero", ifa.resp_valid, 0);
    drive_edge(); rst = 1'b0; d_valid = '0;
    for (int n = 0; n < 10; n++) begin
      drive_edge(); settle();
      chk("t5_quiet", ifa.resp_valid, 0);
    end
    drive_edge(); d_valid = 8'h03; rand_ops(2);
    settle();
    chk("t5_first_grant", ifa.req_ready, 2'b01);
    drive_edge(); d_valid = '0;
    repeat (8) drive_edge();

    // Randomized traffic on the 4-requester, latency-1 instance
    drive_edge(); rst = 1'b1; mode = 1; d_valid = '0; d_rrdy = 8'hFF;
    drive_edge();
    drive_edge(); rst = 1'b0;
    for (int n = 0; n < 10000; n++) begin
      drive_edge();
      d_valid = 8'($urandom) & 8'h0F;
      for (int k = 0; k < 4; k++) d_rrdy[k] = ($urandom_range(0, 3) != 0);
      rand_ops(4);
    end
    drive_edge(); d_valid = '0; d_rrdy = 8'hFF;
    repeat (6) drive_edge();
    settle();
    chk("b_no_loss", m_cons, m_acc);
    chk("b_activity", m_acc > 1000, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
